// File: rtl/dds_phase_bank_pkg.sv
// Shared types for the multi-channel DDS phase-accumulator bank.
package dds_pkg;
  localparam int MAX_W = 48;

  typedef enum logic [1:0] {
    SEL_TARGET = 2'd0,
    SEL_STEP   = 2'd1,
    SEL_OFFSET = 2'd2,
    SEL_RSVD   = 2'd3
  } cfg_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

  // Fields sized for the widest accumulator; channels use the low ACC_WIDTH bits.
  typedef struct packed {
    logic [MAX_W-1:0] target;
    logic [MAX_W-1:0] step;
    logic [MAX_W-1:0] offset;
  } ch_cfg_t;
endpackage

// File: rtl/dds_phase_bank_if.sv
// Config write port of the DDS bank: valid/ready write with one-cycle error pulse.
interface dds_phase_bank_if
  import dds_pkg::*;
#(parameter int ACC_WIDTH = 32);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [3:0]           cfg_ch;
  cfg_sel_t             cfg_sel;
  logic [ACC_WIDTH-1:0] cfg_data;
  logic                 cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_sel, cfg_data, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_sel, cfg_data, output cfg_ready, cfg_err);
endinterface

// File: rtl/dds_phase_bank_channel.sv
// One DDS channel: accumulator, phase offset, registered MSB output and slew-limited increment ramp.
module dds_channel
  import dds_pkg::*;
#(
  parameter int                   ACC_WIDTH   = 32,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = '0
) (
  input  logic                 clk_ref,
  input  logic                 clk_ref_aresetn,
  input  ch_cfg_t              cfg_i,
  input  logic                 ramp_tick_i,
  input  logic                 phase_sync_i,
  output logic                 dds_o,
  output logic                 ramp_busy_o,
  output logic [ACC_WIDTH-1:0] cur_inc_o
);
  logic [ACC_WIDTH-1:0] tgt, stp, off, acc_q, inc_q, phase, diff, delta, stepped;
  logic                 up, dds_q;
  ramp_state_t          st_q;

  assign tgt = cfg_i.target[ACC_WIDTH-1:0];
  assign stp = cfg_i.step[ACC_WIDTH-1:0];
  assign off = cfg_i.offset[ACC_WIDTH-1:0];

  if (ACC_WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{cfg_i.target[MAX_W-1:ACC_WIDTH], cfg_i.step[MAX_W-1:ACC_WIDTH],
                         cfg_i.offset[MAX_W-1:ACC_WIDTH]};
  end

  // Move toward target by min(step, distance); a zero step mid-ramp finishes on the next tick.
  assign up      = tgt > inc_q;
  assign diff    = up ? tgt - inc_q : inc_q - tgt;
  assign delta   = (stp == '0 || stp > diff) ? diff : stp;
  assign stepped = up ? inc_q + delta : inc_q - delta;
  assign phase   = acc_q + off;

  logic unused_phase;
  assign unused_phase = ^phase[ACC_WIDTH-2:0];

  always_ff @(posedge clk_ref or negedge clk_ref_aresetn) begin
    if (!clk_ref_aresetn) begin
      acc_q <= '0;
      inc_q <= DEFAULT_INC;
      st_q  <= IDLE;
      dds_q <= 1'b0;
    end else begin
      acc_q <= phase_sync_i ? '0 : acc_q + inc_q;
      dds_q <= phase[ACC_WIDTH-1];
      case (st_q)
        IDLE: if (tgt != inc_q) begin
          if (stp == '0) inc_q <= tgt;
          else           st_q  <= RAMP;
        end
        RAMP: if (ramp_tick_i) begin
          inc_q <= stepped;
          if (stepped == tgt) st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign dds_o       = dds_q;
  assign ramp_busy_o = (st_q == RAMP);
  assign cur_inc_o   = inc_q;
endmodule

// File: rtl/dds_phase_bank.sv
// Multi-channel DDS bank: config decode, shared ramp prescaler and the channel array.
module dds_phase_bank
  import dds_pkg::*;
#(
  parameter int                   N_CH        = 4,
  parameter int                   ACC_WIDTH   = 32,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = ACC_WIDTH'(32'h051EB852),
  parameter int                   RAMP_DIV    = 16
) (
  input  logic                      clk_ref,
  input  logic                      clk_ref_aresetn,
  dds_phase_bank_if.slave           cfg,
  input  logic                      phase_sync,
  output logic [N_CH-1:0]           dds_out,
  output logic [N_CH-1:0]           ramp_busy,
  output logic [N_CH*ACC_WIDTH-1:0] cur_inc
);
  localparam int            PW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] TICK_AT = PW'(RAMP_DIV - 1);

  ch_cfg_t [N_CH-1:0] cfg_q, cfg_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               ready_q, err_q, err_d, accept, wr_ok, ramp_tick;

  assign accept    = cfg.cfg_valid & ready_q;
  assign wr_ok     = (32'(cfg.cfg_ch) < N_CH) && (cfg.cfg_sel != SEL_RSVD);
  assign ramp_tick = (presc_q == TICK_AT);

  always_comb begin
    cfg_d = cfg_q;
    for (int c = 0; c < N_CH; c++) begin
      if (accept && wr_ok && 32'(cfg.cfg_ch) == c) begin
        case (cfg.cfg_sel)
          SEL_TARGET: cfg_d[c].target = MAX_W'(cfg.cfg_data);
          SEL_STEP:   cfg_d[c].step   = MAX_W'(cfg.cfg_data);
          SEL_OFFSET: cfg_d[c].offset = MAX_W'(cfg.cfg_data);
          default: ;
        endcase
      end
    end
    err_d   = accept & ~wr_ok;
    presc_d = (phase_sync || ramp_tick) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk_ref or negedge clk_ref_aresetn) begin
    if (!clk_ref_aresetn) begin
      for (int c = 0; c < N_CH; c++)
        cfg_q[c] <= '{target: MAX_W'(DEFAULT_INC), step: '0, offset: '0};
      presc_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      presc_q <= presc_d;
      ready_q <= 1'b1;
      err_q   <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    dds_channel #(.ACC_WIDTH(ACC_WIDTH), .DEFAULT_INC(DEFAULT_INC)) u_ch (
      .clk_ref        (clk_ref),
      .clk_ref_aresetn(clk_ref_aresetn),
      .cfg_i          (cfg_q[g]),
      .ramp_tick_i    (ramp_tick),
      .phase_sync_i   (phase_sync),
      .dds_o          (dds_out[g]),
      .ramp_busy_o    (ramp_busy[g]),
      .cur_inc_o      (cur_inc[g*ACC_WIDTH +: ACC_WIDTH])
    );
  end
endmodule

// File: tb/tb_dds_phase_bank.sv
// Bench for dds_phase_bank: 8-bit ramp table on a small instance, directed and model-checked random on the 32-bit one.
module tb_dds_phase_bank;
  import dds_pkg::*;
  localparam int          NCH  = 4;
  localparam int          DIV  = 16;
  localparam logic [31:0] DINC = 32'h051EB852;
  localparam logic [7:0]  SINC = 8'h10;

  logic clk = 1'b0, rst_n = 1'b0, sync = 1'b0, s_sync = 1'b0;
  always #5 clk = ~clk;

  dds_phase_bank_if #(.ACC_WIDTH(32)) cif ();
  dds_phase_bank_if #(.ACC_WIDTH(8))  sif ();
  logic [NCH-1:0]    dds, busy, s_dds, s_busy;
  logic [NCH*32-1:0] cur;
  logic [NCH*8-1:0]  s_cur;

  dds_phase_bank #(.N_CH(NCH), .ACC_WIDTH(32), .DEFAULT_INC(DINC), .RAMP_DIV(DIV)) dut (
    .clk_ref(clk), .clk_ref_aresetn(rst_n), .cfg(cif), .phase_sync(sync),
    .dds_out(dds), .ramp_busy(busy), .cur_inc(cur));
  dds_phase_bank #(.N_CH(NCH), .ACC_WIDTH(8), .DEFAULT_INC(SINC), .RAMP_DIV(4)) dut_s (
    .clk_ref(clk), .clk_ref_aresetn(rst_n), .cfg(sif), .phase_sync(s_sync),
    .dds_out(s_dds), .ramp_busy(s_busy), .cur_inc(s_cur));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mcur(input int c);
    return cur[c*32 +: 32];
  endfunction

  task automatic mwr(input int ch, input int sel, input logic [31:0] d);
    cif.cfg_valid = 1'b1; cif.cfg_ch = 4'(ch); cif.cfg_sel = cfg_sel_t'(sel); cif.cfg_data = d;
    @(negedge clk);
    cif.cfg_valid = 1'b0;
  endtask

  // Ramp reference: move toward target by at most step, never past it; zero step jumps.
  function automatic logic [31:0] approach(input logic [31:0] c, input logic [31:0] t, input logic [31:0] s);
    longint d, mag;
    d   = longint'(t) - longint'(c);
    mag = (d < 0) ? -d : d;
    if (s == 0 || longint'(s) >= mag) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  typedef struct {
    bit vld; int sel; int ch; logic [7:0] data; int adv;
    logic [7:0] cur; bit busy; bit err;
  } rvec_t;
  rvec_t tbl[$];

  function automatic rvec_t mk(bit v, int s, int c, logic [7:0] d, int a, logic [7:0] e, bit b, bit er);
    rvec_t r;
    r.vld = v; r.sel = s; r.ch = c; r.data = d; r.adv = a; r.cur = e; r.busy = b; r.err = er;
    return r;
  endfunction

  logic [31:0] m_tgt[NCH], m_stp[NCH], m_off[NCH], m_cur[NCH], m_acc[NCH], ph;
  logic [NCH-1:0] m_dds, m_busy;
  bit   m_rdy, m_err;
  int   m_cnt, rises, bad;
  logic prev;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cfg_valid = 0; cif.cfg_ch = 0; cif.cfg_sel = SEL_TARGET; cif.cfg_data = 0;
    sif.cfg_valid = 0; sif.cfg_ch = 0; sif.cfg_sel = SEL_TARGET; sif.cfg_data = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("rst.cur%0d", c), mcur(c), DINC);
      chk($sformatf("rst.scur%0d", c), s_cur[c*8 +: 8], SINC);
    end
    chk("rst.dds", {s_dds, dds}, 0);
    chk("rst.busy", {s_busy, busy}, 0);
    chk("rst.ready", {sif.cfg_ready, cif.cfg_ready}, 0);
    chk("rst.err", {sif.cfg_err, cif.cfg_err}, 0);
    @(negedge clk);
    chk("rst.ready_up", {sif.cfg_ready, cif.cfg_ready}, 2'b11);

    // 8-bit ramp: prescaler tick every 4 cycles, step 3, up to 0x18, then up/retarget down to 0x12.
    tbl.push_back(mk(1, 1, 0, 8'h03, 1, 8'h10, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h18, 1, 8'h10, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h10, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4, 8'h13, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 3, 8'h13, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h16, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4, 8'h18, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h30, 1, 8'h18, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h18, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 2, 8'h1B, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h12, 4, 8'h18, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4, 8'h15, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4, 8'h12, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8, 8'h12, 0, 0));
    tbl.push_back(mk(1, 0, 5, 8'h40, 1, 8'h12, 0, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h12, 0, 0));
    tbl.push_back(mk(1, 3, 0, 8'h40, 1, 8'h12, 0, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4, 8'h12, 0, 0));
    foreach (tbl[i]) begin
      if (tbl[i].vld) begin
        sif.cfg_valid = 1'b1; sif.cfg_ch = 4'(tbl[i].ch);
        sif.cfg_sel = cfg_sel_t'(tbl[i].sel); sif.cfg_data = tbl[i].data;
      end
      repeat (tbl[i].adv) begin
        @(negedge clk);
        sif.cfg_valid = 1'b0;
      end
      chk($sformatf("ramp[%0d].cur", i), s_cur[7:0], tbl[i].cur);
      chk($sformatf("ramp[%0d].busy", i), s_busy[0], tbl[i].busy);
      chk($sformatf("ramp[%0d].err", i), sif.cfg_err, tbl[i].err);
    end

    // Default frequency: inc/2^32 = 0.02, so ~100 rising edges in 5000 cycles.
    rises = 0; prev = dds[0];
    repeat (5000) begin
      @(negedge clk);
      if (dds[0] && !prev) rises++;
      prev = dds[0];
    end
    chk("period50", (rises * 49 <= 5000) && (rises * 51 >= 5000), 1);

    // Jump on ch1.
    mwr(1, 1, 32'h0);
    mwr(1, 0, 32'h80000000);
    chk("jump.pre", mcur(1), DINC);
    chk("jump.busy0", busy[1], 0);
    @(negedge clk);
    chk("jump.cur", mcur(1), 32'h80000000);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      prev = dds[1];
      @(negedge clk);
      if (dds[1] == prev || busy[1]) bad++;
    end
    chk("jump.toggle", bad, 0);

    // Offset half-turn on ch2, then phase_sync aligns ch0/ch2 in antiphase.
    mwr(2, 0, 32'h12345678);
    repeat (5) @(negedge clk);
    mwr(2, 0, DINC);
    repeat (3) @(negedge clk);
    chk("sync.cur2", mcur(2), DINC);
    mwr(2, 2, 32'h80000000);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (dds[2] !== ~dds[0]) bad++;
      @(negedge clk);
    end
    chk("sync.antiphase", bad, 0);

    // Write and phase_sync together.
    cif.cfg_valid = 1'b1; cif.cfg_ch = 4'd3; cif.cfg_sel = SEL_TARGET; cif.cfg_data = 32'h80000000;
    sync = 1'b1;
    @(negedge clk);
    cif.cfg_valid = 1'b0; sync = 1'b0;
    @(negedge clk);
    chk("both.cur3", mcur(3), 32'h80000000);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (dds[0] !== 1'b0 || dds[2] !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("both.synced", bad, 0);

    // Invalid channel / reserved select.
    mwr(5, 0, 32'h0);
    chk("err.ch", cif.cfg_err, 1);
    @(negedge clk);
    chk("err.ch_drop", cif.cfg_err, 0);
    mwr(0, 3, 32'h0);
    chk("err.sel", cif.cfg_err, 1);
    repeat (3) @(negedge clk);
    chk("err.sel_drop", cif.cfg_err, 0);
    chk("err.cur0", mcur(0), DINC);
    chk("err.cur1", mcur(1), 32'h80000000);
    chk("err.cur2", mcur(2), DINC);
    chk("err.cur3", mcur(3), 32'h80000000);

    // Async reset mid-ramp.
    mwr(0, 1, 32'h00100000);
    mwr(0, 0, 32'h10000000);
    repeat (40) @(negedge clk);
    chk("arst.busy_pre", busy[0], 1);
    chk("arst.cur_pre", (mcur(0) > DINC) && ((mcur(0) - DINC) % 32'h00100000 == 0), 1);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++) chk($sformatf("arst.cur%0d", c), mcur(c), DINC);
    chk("arst.dds", dds, 0);
    chk("arst.busy", busy, 0);
    chk("arst.ready", cif.cfg_ready, 0);
    chk("arst.err", cif.cfg_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the reference model, starting from reset values.
    for (int c = 0; c < NCH; c++) begin
      m_tgt[c] = DINC; m_stp[c] = 0; m_off[c] = 0; m_cur[c] = DINC; m_acc[c] = 0;
    end
    m_dds = 0; m_busy = 0; m_rdy = 0; m_err = 0; m_cnt = 0;
    for (int it = 0; it < 3000; it++) begin
      logic [31:0] d;
      int ch, sel;
      bit v, sy, tick;
      v   = ($urandom_range(0, 99) < 35);
      ch  = $urandom_range(0, 5);
      sel = $urandom_range(0, 3);
      d   = $urandom;
      if (sel == 1) d = ($urandom_range(0, 2) == 0) ? 32'h0 : d >> $urandom_range(6, 14);
      sy  = ($urandom_range(0, 49) == 0);
      cif.cfg_valid = v; cif.cfg_ch = 4'(ch); cif.cfg_sel = cfg_sel_t'(sel); cif.cfg_data = d;
      sync = sy;
      tick = (m_cnt % DIV) == DIV - 1;
      for (int c = 0; c < NCH; c++) begin
        ph = m_acc[c] + m_off[c];
        m_dds[c] = ph[31];
        m_acc[c] = sy ? 32'h0 : m_acc[c] + m_cur[c];
        if (!m_busy[c]) begin
          if (m_tgt[c] != m_cur[c]) begin
            if (m_stp[c] == 0) m_cur[c] = m_tgt[c];
            else m_busy[c] = 1'b1;
          end
        end else if (tick) begin
          m_cur[c] = approach(m_cur[c], m_tgt[c], m_stp[c]);
          if (m_cur[c] == m_tgt[c]) m_busy[c] = 1'b0;
        end
      end
      m_err = v && m_rdy && (ch >= NCH || sel == 3);
      if (v && m_rdy && ch < NCH) begin
        case (sel)
          0: m_tgt[ch] = d;
          1: m_stp[ch] = d;
          2: m_off[ch] = d;
          default: ;
        endcase
      end
      m_cnt = sy ? 0 : m_cnt + 1;
      m_rdy = 1'b1;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) chk($sformatf("rnd%0d.cur%0d", it, c), mcur(c), m_cur[c]);
      chk($sformatf("rnd%0d.dds", it), dds, m_dds);
      chk($sformatf("rnd%0d.busy", it), busy, m_busy);
      chk($sformatf("rnd%0d.err", it), cif.cfg_err, m_err);
      chk($sformatf("rnd%0d.ready", it), cif.cfg_ready, m_rdy);
    end
    cif.cfg_valid = 1'b0; sync = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
